// File: rtl/twiddle_stream_gen.sv
// Radix-2 FFT twiddle streamer: quarter-wave cosine table, 3-stage pipeline, valid/ready output.
// Optional conjugated output for inverse transforms when TWIDDLE_INVERSE_EN is defined.
module twiddle_stream_gen #(
    parameter int WORD_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int LOG2N     = 5,
    parameter     INIT_FILE = "twiddle_q.hex"
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [$clog2(LOG2N)-1:0] i_stage,
`ifdef TWIDDLE_INVERSE_EN
    input  logic                     i_inverse,
`endif
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [WORD_SIZE-1:0]     o_re,
    output logic [WORD_SIZE-1:0]     o_im,
    output logic [LOG2N-2:0]         o_index,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int SW = $clog2(LOG2N);
    localparam int AW = LOG2N - 1;
    localparam int QN = (1 << (LOG2N - 2)) + 1;
    localparam int QW = FRAC_BITS + 1;
    localparam int CF = 30;
    localparam longint TWO_PI_F = 64'sd6746518852;
    localparam logic [AW-1:0] QUARTER = AW'(1 << (LOG2N - 2));

    // Quarter-wave table built at elaboration; holds the same values INIT_FILE carries:
    // Q[i] = round(cos(2*pi*i/N) * 2^FRAC_BITS), via a fixed-point Taylor series.
    function automatic logic [QN*QW-1:0] build_rom();
        logic [QN*QW-1:0] r;
        longint x, x2, term, sum, q;
        r = '0;
        for (int i = 0; i < QN; i++) begin
            x    = (TWO_PI_F * longint'(i)) >>> LOG2N;
            x2   = (x * x) >>> CF;
            term = longint'(1) <<< CF;
            sum  = term;
            for (int n = 1; n <= 12; n++) begin
                term = -((term * x2) >>> CF) / longint'((2 * n - 1) * (2 * n));
                sum  = sum + term;
            end
            q = (sum + (longint'(1) <<< (CF - FRAC_BITS - 1))) >>> (CF - FRAC_BITS);
            if (q < 0) q = 0;
            r[i*QW +: QW] = QW'(q);
        end
        return r;
    endfunction

    localparam logic [QN*QW-1:0] ROM_FLAT = build_rom();

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [AW-1:0]   k_q, k_d;
    logic            issue_q, issue_d;
    logic [2:0]      vld_pipe_q, vld_pipe_d;
    logic [AW-1:0]   s1_re_addr_q, s1_re_addr_d, s1_im_addr_q, s1_im_addr_d;
    logic [AW-1:0]   s1_idx_q, s1_idx_d;
    logic            s1_neg_q, s1_neg_d, s1_last_q, s1_last_d;
    logic [QW-1:0]   s2_re_q, s2_re_d, s2_im_q, s2_im_d;
    logic [AW-1:0]   s2_idx_q, s2_idx_d;
    logic            s2_neg_q, s2_neg_d, s2_last_q, s2_last_d;
    logic [WORD_SIZE-1:0] o_re_q, o_re_d, o_im_q, o_im_d;
    logic [AW-1:0]   o_idx_q, o_idx_d;
    logic            o_last_q, o_last_d, o_err_q, o_err_d;
`ifdef TWIDDLE_INVERSE_EN
    logic            inv_q, inv_d;
`endif

    logic                 en;
    logic [SW-1:0]        shamt;
    logic [AW-1:0]        e, last_k;
    logic                 le_quarter;
    logic [WORD_SIZE-1:0] re_ext, im_ext;

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        k_d          = k_q;
        issue_d      = issue_q;
        vld_pipe_d   = vld_pipe_q;
        s1_re_addr_d = s1_re_addr_q;
        s1_im_addr_d = s1_im_addr_q;
        s1_idx_d     = s1_idx_q;
        s1_neg_d     = s1_neg_q;
        s1_last_d    = s1_last_q;
        s2_re_d      = s2_re_q;
        s2_im_d      = s2_im_q;
        s2_idx_d     = s2_idx_q;
        s2_neg_d     = s2_neg_q;
        s2_last_d    = s2_last_q;
        o_re_d       = o_re_q;
        o_im_d       = o_im_q;
        o_idx_d      = o_idx_q;
        o_last_d     = o_last_q;
        o_err_d      = 1'b0;
`ifdef TWIDDLE_INVERSE_EN
        inv_d        = inv_q;
`endif

        en         = !vld_pipe_q[2] || i_ready;
        shamt      = SW'(AW) - stage_q;
        e          = k_q << shamt;
        last_k     = ~({AW{1'b1}} << stage_q);
        le_quarter = (e <= QUARTER);
        re_ext     = {{(WORD_SIZE-QW){1'b0}}, s2_re_q};
        im_ext     = {{(WORD_SIZE-QW){1'b0}}, s2_im_q};

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if ({1'b0, i_stage} >= (SW+1)'(LOG2N)) begin
                        o_err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        stage_d = i_stage;
                        k_d     = '0;
                        issue_d = 1'b1;
`ifdef TWIDDLE_INVERSE_EN
                        inv_d   = i_inverse;
`endif
                    end
                end
            end
            S_RUN: begin
                if (vld_pipe_q[2] && i_ready && o_last_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (en) begin
            // P1: fold exponent into cos/sin table addresses; past N/4 cos is mirrored and negated
            vld_pipe_d[0] = (state_q == S_RUN) && issue_q;
            if ((state_q == S_RUN) && issue_q) begin
                s1_re_addr_d = le_quarter ? e : ({AW{1'b0}} - e);
                s1_im_addr_d = le_quarter ? (QUARTER - e) : (e - QUARTER);
                s1_neg_d     = !le_quarter;
                s1_idx_d     = k_q;
                s1_last_d    = (k_q == last_k);
                if (k_q == last_k) issue_d = 1'b0;
                else               k_d     = k_q + 1'b1;
            end

            // P2: registered table read
            vld_pipe_d[1] = vld_pipe_q[0];
            s2_re_d       = ROM_FLAT[int'(s1_re_addr_q)*QW +: QW];
            s2_im_d       = ROM_FLAT[int'(s1_im_addr_q)*QW +: QW];
            s2_idx_d      = s1_idx_q;
            s2_neg_d      = s1_neg_q;
            s2_last_d     = s1_last_q;

            // P3: sign application into the output register
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                o_re_d   = s2_neg_q ? -re_ext : re_ext;
`ifdef TWIDDLE_INVERSE_EN
                o_im_d   = inv_q ? -im_ext : im_ext;
`else
                o_im_d   = im_ext;
`endif
                o_idx_d  = s2_idx_q;
                o_last_d = s2_last_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            stage_q      <= '0;
            k_q          <= '0;
            issue_q      <= 1'b0;
            vld_pipe_q   <= '0;
            s1_re_addr_q <= '0;
            s1_im_addr_q <= '0;
            s1_idx_q     <= '0;
            s1_neg_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_re_q      <= '0;
            s2_im_q      <= '0;
            s2_idx_q     <= '0;
            s2_neg_q     <= 1'b0;
            s2_last_q    <= 1'b0;
            o_re_q       <= '0;
            o_im_q       <= '0;
            o_idx_q      <= '0;
            o_last_q     <= 1'b0;
            o_err_q      <= 1'b0;
`ifdef TWIDDLE_INVERSE_EN
            inv_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            k_q          <= k_d;
            issue_q      <= issue_d;
            vld_pipe_q   <= vld_pipe_d;
            s1_re_addr_q <= s1_re_addr_d;
            s1_im_addr_q <= s1_im_addr_d;
            s1_idx_q     <= s1_idx_d;
            s1_neg_q     <= s1_neg_d;
            s1_last_q    <= s1_last_d;
            s2_re_q      <= s2_re_d;
            s2_im_q      <= s2_im_d;
            s2_idx_q     <= s2_idx_d;
            s2_neg_q     <= s2_neg_d;
            s2_last_q    <= s2_last_d;
            o_re_q       <= o_re_d;
            o_im_q       <= o_im_d;
            o_idx_q      <= o_idx_d;
            o_last_q     <= o_last_d;
            o_err_q      <= o_err_d;
`ifdef TWIDDLE_INVERSE_EN
            inv_q        <= inv_d;
`endif
        end
    end

    assign o_valid = vld_pipe_q[2];
    assign o_re    = o_re_q;
    assign o_im    = o_im_q;
    assign o_index = o_idx_q;
    assign o_last  = o_last_q;
    assign o_busy  = (state_q == S_RUN);
    assign o_err   = o_err_q;

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Bench for twiddle_stream_gen: directed steps plus $urandom back-pressure and stage choice,
// checked against a real-valued cos/sin reference.
module tb_twiddle_stream_gen;
    localparam int  N     = 32;
    localparam int  LOG2N = 5;
    localparam real PI    = 3.14159265358979323846;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start, i_ready;
    logic [2:0]  i_stage;
`ifdef TWIDDLE_INVERSE_EN
    logic        i_inverse;
`endif
    logic        o_valid, o_last, o_busy, o_err;
    logic [15:0] o_re, o_im;
    logic [3:0]  o_index;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] cap_re [16];
    logic [15:0] cap_im [16];
    logic        cap_last [16];

    always #5 i_clk = ~i_clk;

    twiddle_stream_gen #(.WORD_SIZE(16), .FRAC_BITS(8), .LOG2N(LOG2N)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_stage (i_stage),
`ifdef TWIDDLE_INVERSE_EN
        .i_inverse(i_inverse),
`endif
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_re    (o_re),
        .o_im    (o_im),
        .o_index (o_index),
        .o_last  (o_last),
        .o_busy  (o_busy),
        .o_err   (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference: round(trig(2*pi*e/N) * 256), optionally negated, as 16-bit two's complement.
    function automatic logic [15:0] mdl(input int e, input bit sine, input bit neg);
        real th, v;
        int  q;
        th = 2.0 * PI * real'(e) / real'(N);
        v  = sine ? $sin(th) : $cos(th);
        q  = int'($floor(v * 256.0 + 0.5));
        if (neg) q = -q;
        return 16'(q);
    endfunction

    // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0,1
    task automatic run_stream(input int stage, input bit inv, input int mode,
                              input bit lat, input bit poke);
        int m, beats, cyc, e;
        bit stalled;
        logic [15:0] h_re, h_im;
        logic [3:0]  h_idx;
        logic        h_last;
        m = 1 << stage;
        i_stage = 3'(stage);
`ifdef TWIDDLE_INVERSE_EN
        i_inverse = inv;
`endif
        i_start = 1'b1;
        i_ready = 1'b1;
        step();
        i_start = 1'b0;
        chk("busy_on", 32'(o_busy), 32'd1);
        if (lat) begin
            chk("lat_t0", 32'(o_valid), 32'd0);
            step();
            chk("lat_t1", 32'(o_valid), 32'd0);
            step();
            chk("lat_t2", 32'(o_valid), 32'd0);
            step();
            chk("lat_t3", 32'(o_valid), 32'd1);
        end
        beats = 0; cyc = 0; stalled = 1'b0;
        h_re = '0; h_im = '0; h_idx = '0; h_last = 1'b0;
        while (beats < m && cyc < 400) begin
            if (stalled) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_re", 32'(o_re), 32'(h_re));
                chk("hold_im", 32'(o_im), 32'(h_im));
                chk("hold_idx", 32'(o_index), 32'(h_idx));
                chk("hold_last", 32'(o_last), 32'(h_last));
            end else if (o_valid) begin
                e = beats << (LOG2N - 1 - stage);
                chk("idx", 32'(o_index), 32'(beats));
                chk("re", 32'(o_re), 32'(mdl(e, 1'b0, 1'b0)));
                chk("im", 32'(o_im), 32'(mdl(e, 1'b1, inv)));
                chk("last", 32'(o_last), 32'(beats == m - 1));
            end else if (mode == 0 && beats > 0) begin
                chk("gap", 32'(o_valid), 32'd1);
            end
            if (poke) begin
                i_start = (beats == 3);
                i_stage = 3'd1;
            end
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = 1'($urandom_range(0, 1));
                default: i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
            stalled = o_valid && !i_ready;
            h_re = o_re; h_im = o_im; h_idx = o_index; h_last = o_last;
            if (o_valid && i_ready) begin
                cap_re[beats]   = o_re;
                cap_im[beats]   = o_im;
                cap_last[beats] = o_last;
                beats++;
            end
            step();
            cyc++;
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        chk("beats", 32'(beats), 32'(m));
        chk("busy_off", 32'(o_busy), 32'd0);
        chk("valid_off", 32'(o_valid), 32'd0);
        step();
        chk("no_dup", 32'(o_valid), 32'd0);
    endtask

    initial begin
        int c;
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_stage = '0;
`ifdef TWIDDLE_INVERSE_EN
        i_inverse = 1'b0;
`endif
        repeat (3) step();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_re", 32'(o_re), 32'd0);
        chk("rst_im", 32'(o_im), 32'd0);
        chk("rst_index", 32'(o_index), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_rst = 1'b0;
        step();

        run_stream(4, 1'b0, 0, 1'b1, 1'b0);
        chk("s4_k1_re", 32'(cap_re[1]), 32'h00FB);
        chk("s4_k1_im", 32'(cap_im[1]), 32'h0032);
        chk("s4_k8_re", 32'(cap_re[8]), 32'h0000);
        chk("s4_k8_im", 32'(cap_im[8]), 32'h0100);
        chk("s4_k12_re", 32'(cap_re[12]), 32'hFF4B);
        chk("s4_k12_im", 32'(cap_im[12]), 32'h00B5);
        chk("s4_k15_re", 32'(cap_re[15]), 32'hFF05);
        chk("s4_k15_im", 32'(cap_im[15]), 32'h0032);
        chk("s4_k15_last", 32'(cap_last[15]), 32'd1);

        run_stream(2, 1'b0, 0, 1'b1, 1'b0);
        chk("s2_k0_re", 32'(cap_re[0]), 32'h0100);
        chk("s2_k0_im", 32'(cap_im[0]), 32'h0000);
        chk("s2_k1_re", 32'(cap_re[1]), 32'h00B5);
        chk("s2_k1_im", 32'(cap_im[1]), 32'h00B5);
        chk("s2_k2_re", 32'(cap_re[2]), 32'h0000);
        chk("s2_k2_im", 32'(cap_im[2]), 32'h0100);
        chk("s2_k3_re", 32'(cap_re[3]), 32'hFF4B);
        chk("s2_k3_im", 32'(cap_im[3]), 32'h00B5);

        run_stream(4, 1'b0, 2, 1'b0, 1'b0);
        run_stream(4, 1'b0, 1, 1'b0, 1'b0);

        // illegal stage is rejected with a one-cycle error pulse
        i_stage = 3'd5; i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("err_pulse", 32'(o_err), 32'd1);
        chk("err_busy", 32'(o_busy), 32'd0);
        chk("err_valid", 32'(o_valid), 32'd0);
        step();
        chk("err_clear", 32'(o_err), 32'd0);
        chk("err_busy2", 32'(o_busy), 32'd0);
        step(); step();
        chk("err_valid2", 32'(o_valid), 32'd0);

        // start pulses and stage changes mid-stream are ignored
        run_stream(4, 1'b0, 0, 1'b0, 1'b1);

        // reset in the middle of a stream
        i_stage = 3'd4; i_start = 1'b1;
        step();
        i_start = 1'b0;
        c = 0;
        while (!(o_valid && o_index == 4'd5) && c < 50) begin
            step();
            c++;
        end
        chk("mid_reach_k5", 32'(o_index), 32'd5);
        i_rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_last", 32'(o_last), 32'd0);
        chk("mid_rst_re", 32'(o_re), 32'd0);
        i_rst = 1'b0;
        run_stream(3, 1'b0, 0, 1'b1, 1'b0);

        run_stream(0, 1'b0, 0, 1'b1, 1'b0);
        chk("s0_last", 32'(cap_last[0]), 32'd1);

        repeat (6) run_stream(int'($urandom_range(0, 4)), 1'b0, 1, 1'b0, 1'b0);

`ifdef TWIDDLE_INVERSE_EN
        run_stream(3, 1'b1, 0, 1'b1, 1'b0);
        chk("inv_k2_re", 32'(cap_re[2]), 32'h00B5);
        chk("inv_k2_im", 32'(cap_im[2]), 32'hFF4B);
        chk("inv_k0_re", 32'(cap_re[0]), 32'h0100);
        chk("inv_k0_im", 32'(cap_im[0]), 32'h0000);
        run_stream(4, 1'b1, 1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
